// File: rtl/reg_access_scheduler.sv
// Round-robin scheduler for a shared register bank. It turns accepted requests
// into registered E/FunSel/In drive and sequences 4-beat byte-load bursts.
module reg_access_scheduler #(
  parameter int NREG = 4,
  localparam int SW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SW-1:0]   req0_sel,
  input  logic [3:0]      req0_op,
  input  logic [31:0]     req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SW-1:0]   req1_sel,
  input  logic [3:0]      req1_op,
  input  logic [31:0]     req1_data,
  output logic [NREG-1:0] E,
  output logic [2:0]      FunSel,
  output logic [31:0]     In,
  output logic            busy,
  output logic            grant_id,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  localparam logic [2:0] FS_BYTE_LD = 3'b100;
  localparam logic [2:0] FS_BYTE_SH = 3'b110;

  state_t            state, state_n;
  logic [1:0]        beat, beat_n;
  logic              last_grant, last_grant_n;
  logic [31:0]       hold, hold_n;
  logic [SW-1:0]     hsel, hsel_n;
  logic [NREG-1:0]   e_n;
  logic [2:0]        fs_n;
  logic [31:0]       in_n;
  logic              err_n, gid_n;

  logic              free, win, acc;
  logic [SW-1:0]     w_sel;
  logic [3:0]        w_op;
  logic [31:0]       w_data;

  // Out-of-range indices decode to no enable at all.
  function automatic logic [NREG-1:0] onehot(input logic [SW-1:0] s);
    logic [NREG-1:0] r;
    for (int i = 0; i < NREG; i++) r[i] = (s == SW'(i));
    return r;
  endfunction

  // The FSM can take a new op whenever it will be free next cycle.
  assign free = (state == IDLE) || (state == ISSUE) || (state == BURST && beat == 2'd3);
  // Tie goes to the requester that did not win last time.
  assign win  = req1_valid & (~req0_valid | ~last_grant);
  assign acc  = free & (req0_valid | req1_valid);

  // Ready is gated by reset so nothing handshakes while the bank is held off.
  assign req0_ready = reset_n & free & req0_valid & ~win;
  assign req1_ready = reset_n & free & req1_valid &  win;
  assign busy       = (state != IDLE);

  assign w_sel  = win ? req1_sel  : req0_sel;
  assign w_op   = win ? req1_op   : req0_op;
  assign w_data = win ? req1_data : req0_data;

  // Next-state and next bus drive; acceptance outranks completing a burst/issue.
  always_comb begin
    state_n      = state;
    beat_n       = beat;
    last_grant_n = last_grant;
    hold_n       = hold;
    hsel_n       = hsel;
    e_n          = '0;
    fs_n         = FunSel;
    in_n         = In;
    err_n        = 1'b0;
    gid_n        = grant_id;
    if (acc) begin
      last_grant_n = win;
      beat_n       = 2'd0;
      if (!w_op[3]) begin
        state_n = ISSUE;
        gid_n   = win;
        e_n     = onehot(w_sel);
        fs_n    = w_op[2:0];
        in_n    = w_data;
      end else if (w_op == 4'b1000) begin
        state_n = BURST;
        gid_n   = win;
        hold_n  = w_data;
        hsel_n  = w_sel;
        e_n     = onehot(w_sel);
        fs_n    = FS_BYTE_LD;
        in_n    = {24'b0, w_data[31:24]};
      end else begin
        // Reserved op: consumed with no bus cycle, flagged for one cycle.
        state_n = IDLE;
        err_n   = 1'b1;
      end
    end else if (state == BURST && beat != 2'd3) begin
      beat_n = beat + 2'd1;
      e_n    = onehot(hsel);
      fs_n   = FS_BYTE_SH;
      case (beat)
        2'd0:    in_n = {24'b0, hold[23:16]};
        2'd1:    in_n = {24'b0, hold[15:8]};
        default: in_n = {24'b0, hold[7:0]};
      endcase
    end else begin
      state_n = IDLE;
      beat_n  = 2'd0;
    end
  end

  // State and registered bus outputs; reset abandons any burst in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat       <= 2'd0;
      last_grant <= 1'b1;
      hold       <= '0;
      hsel       <= '0;
      E          <= '0;
      FunSel     <= 3'b000;
      In         <= '0;
      err        <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      last_grant <= last_grant_n;
      hold       <= hold_n;
      hsel       <= hsel_n;
      E          <= e_n;
      FunSel     <= fs_n;
      In         <= in_n;
      err        <= err_n;
      grant_id   <= gid_n;
    end
  end

endmodule

// File: tb/tb_reg_access_scheduler.sv
// Directed bench for reg_access_scheduler with a small register-bank model.
module tb_reg_access_scheduler;
  localparam int NREG = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]      req0_sel, req1_sel;
  logic [3:0]      req0_op, req1_op;
  logic [31:0]     req0_data, req1_data;
  logic [NREG-1:0] E;
  logic [2:0]      FunSel;
  logic [31:0]     In;
  logic            busy, grant_id, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] mreg [NREG];

  reg_access_scheduler #(.NREG(NREG)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_op(req1_op), .req1_data(req1_data),
    .E(E), .FunSel(FunSel), .In(In), .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clock = ~clock;

  // Register bank model: dec, inc, load, clear, byte load, byte shift-in.
  always @(posedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        if (E[i]) begin
          case (FunSel)
            3'b000: mreg[i] <= mreg[i] - 32'd1;
            3'b001: mreg[i] <= mreg[i] + 32'd1;
            3'b010: mreg[i] <= In;
            3'b011: mreg[i] <= 32'd0;
            3'b100: mreg[i] <= {24'b0, In[7:0]};
            3'b110: mreg[i] <= {mreg[i][23:0], In[7:0]};
            default: mreg[i] <= mreg[i];
          endcase
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mreg[i] = 32'd0;
    req0_sel = 0; req1_sel = 0; req0_op = 0; req1_op = 0;
    req0_data = 0; req1_data = 0;
    reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    @(negedge clock); #1;
    chk("rst_E", 32'(E), 32'h0);
    chk("rst_FunSel", 32'(FunSel), 32'h0);
    chk("rst_In", In, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdy0", 32'(req0_ready), 32'h0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Single load
    req0_valid = 1; req0_op = 4'b0010; req0_sel = 2; req0_data = 32'hDEADBEEF;
    #1;
    chk("s_rdy0", 32'(req0_ready), 32'h1);
    chk("s_rdy1", 32'(req1_ready), 32'h0);
    cyc(); req0_valid = 0;
    chk("s_E", 32'(E), 32'h4);
    chk("s_FunSel", 32'(FunSel), 32'h2);
    chk("s_In", In, 32'hDEADBEEF);
    chk("s_busy", 32'(busy), 32'h1);
    chk("s_gid", 32'(grant_id), 32'h0);
    cyc();
    chk("s_E_off", 32'(E), 32'h0);
    chk("s_busy_off", 32'(busy), 32'h0);
    chk("s_FunSel_hold", 32'(FunSel), 32'h2);
    chk("s_reg2", mreg[2], 32'hDEADBEEF);

    // Tie round-robin after reset: req0 first, then alternate
    do_reset();
    req0_valid = 1; req0_op = 4'b0001; req0_sel = 0;
    req1_valid = 1; req1_op = 4'b0001; req1_sel = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr_rdy1_%0d", i), 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
      cyc();
      chk($sformatf("rr_gid_%0d", i), 32'(grant_id), 32'(i % 2));
      chk($sformatf("rr_E_%0d", i), 32'(E), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    req0_valid = 0; req1_valid = 0;
    cyc();
    chk("rr_reg0", mreg[0], 32'd4);
    chk("rr_reg1", mreg[1], 32'd4);

    // BYTE4 burst from req1, req0 accepted on beat 3
    req1_valid = 1; req1_op = 4'b1000; req1_sel = 1; req1_data = 32'h12345678;
    #1;
    chk("b_rdy1", 32'(req1_ready), 32'h1);
    cyc(); req1_valid = 0;
    chk("b0_E", 32'(E), 32'h2);
    chk("b0_fs", 32'(FunSel), 32'h4);
    chk("b0_In", In, 32'h12);
    chk("b0_gid", 32'(grant_id), 32'h1);
    cyc();
    chk("b1_E", 32'(E), 32'h2);
    chk("b1_fs", 32'(FunSel), 32'h6);
    chk("b1_In", In, 32'h34);
    cyc();
    req0_valid = 1; req0_op = 4'b0010; req0_sel = 3; req0_data = 32'hA5A5A5A5;
    #1;
    chk("b2_In", In, 32'h56);
    chk("b2_rdy0", 32'(req0_ready), 32'h0);
    cyc();
    chk("b3_E", 32'(E), 32'h2);
    chk("b3_fs", 32'(FunSel), 32'h6);
    chk("b3_In", In, 32'h78);
    chk("b3_rdy0", 32'(req0_ready), 32'h1);
    cyc(); req0_valid = 0;
    chk("bn_E", 32'(E), 32'h8);
    chk("bn_In", In, 32'hA5A5A5A5);
    chk("bn_gid", 32'(grant_id), 32'h0);
    chk("b_reg1", mreg[1], 32'h12345678);
    cyc();
    chk("bn_reg3", mreg[3], 32'hA5A5A5A5);

    // Reserved op
    req0_valid = 1; req0_op = 4'b1011; req0_sel = 0; req0_data = 32'hFFFFFFFF;
    cyc(); req0_valid = 0;
    chk("rsv_E", 32'(E), 32'h0);
    chk("rsv_err", 32'(err), 32'h1);
    chk("rsv_busy", 32'(busy), 32'h0);
    cyc();
    chk("rsv_err_off", 32'(err), 32'h0);
    chk("rsv_reg0", mreg[0], 32'd4);

    // Reset during beat 1 of a burst
    req0_valid = 1; req0_op = 4'b1000; req0_sel = 2; req0_data = 32'hCAFEF00D;
    cyc(); req0_valid = 0;
    cyc();
    chk("mr_b1_In", In, 32'hFE);
    reset_n = 0; #1;
    chk("mr_E", 32'(E), 32'h0);
    chk("mr_fs", 32'(FunSel), 32'h0);
    chk("mr_In", In, 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    cyc();
    chk("mr_reg2", mreg[2], 32'h000000CA);
    reset_n = 1;
    req0_valid = 1; req0_op = 4'b0011; req0_sel = 0;
    req1_valid = 1; req1_op = 4'b0011; req1_sel = 1;
    #1;
    chk("mr_rdy0", 32'(req0_ready), 32'h1);
    chk("mr_rdy1", 32'(req1_ready), 32'h0);
    cyc(); req0_valid = 0; req1_valid = 0;
    chk("mr_gid", 32'(grant_id), 32'h0);
    cyc();

    // Back-to-back increments on sel 3
    req0_valid = 1; req0_op = 4'b0001; req0_sel = 3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bb_rdy_%0d", i), 32'(req0_ready), 32'h1);
      cyc();
      chk($sformatf("bb_E_%0d", i), 32'(E), 32'h8);
    end
    req0_valid = 0;
    cyc();
    chk("bb_E_off", 32'(E), 32'h0);
    chk("bb_reg3", mreg[3], 32'hA5A5A5AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
